gin_mc_bus: RTL and testbench
=============================

# gin_mc_bus

Global input network multicast bus for one PE row. It sits directly upstream of the PE input FIFOs (ifmap, weight or psum_in) of `NUM_PE` PEs. It takes a single tagged stream from the global buffer and delivers each datum to every PE whose configured ID matches the tag, using per-PE valid/ready handshakes. One instance is used per data type per row; PE IDs are loaded serially after reset or on request.

## Interface
Parameters:
- `DATA_BITWIDTH`, 8: width of data word, matches the PE FIFO element width.
- `ID_WIDTH`, 5: width of tag and PE ID; the all-ones tag is broadcast.
- `NUM_PE`, 12: number of PE destinations on the bus.
- `DROP_CNT_WIDTH`, 16: width of the saturating dropped-packet counter.

Ports:
- `i_clk`, input, 1: single clock; all state is rising-edge.
- `i_rst`, input, 1: reset, asynchronous and active-low.
- `i_cfg_clear`, input, 1: one-cycle pulse that restarts ID configuration.
- `i_id_cfg_valid`, input, 1: ID write strobe.
- `i_id_cfg_data`, input, `ID_WIDTH`: ID for the PE at the current config index.
- `o_cfg_done`, output, 1: high once all `NUM_PE` IDs are loaded.
- `i_tag`, input, `ID_WIDTH`: destination tag of the upstream word.
- `i_data`, input, `DATA_BITWIDTH`: upstream data.
- `i_valid`, input, 1: upstream valid.
- `o_ready`, output, 1: upstream ready.
- `o_pe_data`, output, `NUM_PE*DATA_BITWIDTH`: per-PE data, with PE k in slice [k*DATA_BITWIDTH +: DATA_BITWIDTH].
- `o_pe_valid`, output, `NUM_PE`: per-PE valid, driven to the PE FIFO push valid.
- `i_pe_ready`, input, `NUM_PE`: per-PE FIFO ready.
- `o_drop_cnt`, output, `DROP_CNT_WIDTH`: number of accepted words that matched no PE.
- `o_busy`, output, 1: OR of `o_pe_valid`.

## Operation
The block has two states, CFG and RUN. Reset state is CFG with config index 0.
- **CFG**:
  - Each cycle with `i_id_cfg_valid` high writes `id_reg[idx]`, then `idx++`.
  - The write at `idx == NUM_PE-1` moves to RUN and sets `o_cfg_done`.
  - `o_ready` is held 0 in CFG.
- **RUN**:
  - `i_id_cfg_valid` is ignored.
  - `i_cfg_clear` moves to CFG, sets `idx=0` and clears `o_cfg_done`.
  - The ID registers keep their old values until overwritten.
  - Output slots that are already full keep draining normally.
- `i_cfg_clear` in CFG also resets `idx` to 0. If `i_cfg_clear` and `i_id_cfg_valid` are asserted in the same cycle, clear wins and no write happens.
- **Match**: `match[k] = (i_tag == id_reg[k]) | (i_tag == all-ones)`.
- **Per-PE output slot**: one-entry register (`o_pe_valid[k]`, data[k]).
  - The slot is free if `!o_pe_valid[k] | i_pe_ready[k]` (drain and refill in the same cycle is allowed).
- **Acceptance**:
  - `o_ready = RUN & AND over k of (!match[k] | slot_free[k])`.
  - All-or-nothing multicast: no PE is written unless every matched PE can take the word.
  - `o_ready` is combinational from `i_tag`, `i_pe_ready` and state.
- **On accept** (`i_valid & o_ready`): each matched slot loads `i_data` and sets valid. Slots that do not match are unaffected, except by their own drain.
- **Drain**: `o_pe_valid[k] & i_pe_ready[k]` with no refill clears `o_pe_valid[k]`.
- **No-match word**:
  - The word is accepted (`o_ready = 1` in RUN) and discarded.
  - `o_drop_cnt` increments and saturates at all-ones.
- **Duplicate IDs** are legal: all PEs carrying the same ID receive the word.
- **Reset values**: `o_pe_valid = 0`, `o_pe_data = 0`, `o_drop_cnt = 0`, `o_cfg_done = 0`, `o_busy = 0`, `o_ready = 0`, all `id_reg = 0`, `idx = 0`.

## Timing
- Latency is one cycle. A word accepted at edge N appears on `o_pe_valid`/`o_pe_data` right after edge N.
- Throughput is one word per cycle per matched PE set while the PEs stay ready.
- `o_pe_valid[k]` is never deasserted before a handshake, and `o_pe_data[k]` is stable while valid and not ready.
- The first accept is possible on the cycle after the final ID write.
- Reset assertion mid-transfer clears all slots immediately, independent of the clock. Data held in the slots is lost.
- Reset release is synchronised externally; the block requires no clock edge while `i_rst` is low.

## Structure
- **Shared package `gin_pkg`**:
  - `BCAST_TAG` (all-ones) constant.
  - State enum `{CFG, RUN}`.
  - Default `ID_WIDTH` and `DATA_BITWIDTH`.
- **Sub-module `gin_mc_slot`**: a one-entry valid/ready register per PE, with inputs load, data and ready and outputs valid, data and free. It is instantiated `NUM_PE` times with a generate loop.
- The top level holds the ID registers, config FSM, match/accept logic and drop counter.

## Test plan
- **ID load and unicast**: after reset, load IDs 0..11 and send tag 3, data 0xA5 with all PEs ready → `o_cfg_done = 1` after 12 writes; only `o_pe_valid[3]` rises, one cycle after accept, with data 0xA5.
- **Broadcast with back-pressure**: send tag 31 with `i_pe_ready[7] = 0` and slot 7 full → `o_ready = 0`, no slot loads. Raise `i_pe_ready[7]` → accept happens that cycle and all 12 slots go valid.
- **Multicast with duplicate IDs**: IDs of PE 2, 5 and 9 = 4; send tag 4 → exactly those three slots load, and `o_drop_cnt` is unchanged.
- **No-match drop and saturation**: tag 20 with no PE matching → accepted and dropped, `o_drop_cnt = 1`. With `DROP_CNT_WIDTH = 2`, five drops → counter holds 3.
- **Reconfig mid-stream**: pulse `i_cfg_clear` while slots 0 and 1 are valid → `o_ready = 0` and `o_cfg_done = 0`; slots 0 and 1 still drain on ready; the new IDs load from idx 0.
- **Reset mid-operation**: assert `i_rst` low with 4 slots valid → all `o_pe_valid` and `o_drop_cnt` go to 0 immediately without a clock edge, and the state returns to CFG.

Source files
------------

// File: rtl/gin_pkg.sv
// Shared definitions for the global input network multicast bus.
package gin_pkg;

  localparam int unsigned DEF_ID_WIDTH       = 5;
  localparam int unsigned DEF_DATA_BITWIDTH  = 8;
  localparam int unsigned DEF_NUM_PE         = 12;
  localparam int unsigned DEF_DROP_CNT_WIDTH = 16;

  localparam logic [DEF_ID_WIDTH-1:0] BCAST_TAG = '1;

  typedef enum logic {
    CFG = 1'b0,
    RUN = 1'b1
  } state_e;

endpackage

// File: rtl/gin_mc_bus_if.sv
// Upstream stream, ID config and per-PE fan-out signals of one multicast bus.
interface gin_mc_bus_if
  import gin_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH  = DEF_DATA_BITWIDTH,
  parameter int unsigned ID_WIDTH       = DEF_ID_WIDTH,
  parameter int unsigned NUM_PE         = DEF_NUM_PE,
  parameter int unsigned DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH
);

  logic                            i_cfg_clear;
  logic                            i_id_cfg_valid;
  logic [ID_WIDTH-1:0]             i_id_cfg_data;
  logic                            o_cfg_done;
  logic [ID_WIDTH-1:0]             i_tag;
  logic [DATA_BITWIDTH-1:0]        i_data;
  logic                            i_valid;
  logic                            o_ready;
  logic [NUM_PE*DATA_BITWIDTH-1:0] o_pe_data;
  logic [NUM_PE-1:0]               o_pe_valid;
  logic [NUM_PE-1:0]               i_pe_ready;
  logic [DROP_CNT_WIDTH-1:0]       o_drop_cnt;
  logic                            o_busy;

  modport master (
    output i_cfg_clear, i_id_cfg_valid, i_id_cfg_data,
    output i_tag, i_data, i_valid, i_pe_ready,
    input  o_cfg_done, o_ready, o_pe_data, o_pe_valid, o_drop_cnt, o_busy
  );

  modport slave (
    input  i_cfg_clear, i_id_cfg_valid, i_id_cfg_data,
    input  i_tag, i_data, i_valid, i_pe_ready,
    output o_cfg_done, o_ready, o_pe_data, o_pe_valid, o_drop_cnt, o_busy
  );

endinterface

// File: rtl/gin_mc_slot.sv
// One-entry valid/ready output register feeding a single PE input FIFO.
module gin_mc_slot
  import gin_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = DEF_DATA_BITWIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [DATA_BITWIDTH-1:0] wdata,
  input  logic                     ready,
  output logic                     valid,
  output logic [DATA_BITWIDTH-1:0] rdata,
  output logic                     free
);

  // Free when empty or draining this cycle, so a refill can overlap the drain.
  assign free = ~valid | ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rdata <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rdata <= wdata;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gin_mc_bus.sv
// Tagged multicast from the global buffer to a row of PEs with all-or-nothing
// acceptance, serially loaded PE IDs and a saturating dropped-word counter.
module gin_mc_bus
  import gin_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH  = DEF_DATA_BITWIDTH,
  parameter int unsigned ID_WIDTH       = DEF_ID_WIDTH,
  parameter int unsigned NUM_PE         = DEF_NUM_PE,
  parameter int unsigned DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH
) (
  input  logic        i_clk,
  input  logic        i_rst,
  gin_mc_bus_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUM_PE - 1);
  localparam logic [ID_WIDTH-1:0]       ALL_ONES = {ID_WIDTH{1'b1}};
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};

  state_e                          state;
  logic [IDX_W-1:0]                idx;
  logic                            cfg_done;
  logic [ID_WIDTH-1:0]             id_reg [NUM_PE];
  logic [DROP_CNT_WIDTH-1:0]       drop_cnt;
  logic [NUM_PE-1:0]               match;
  logic [NUM_PE-1:0]               slot_free;
  logic [NUM_PE-1:0]               load;
  logic [NUM_PE-1:0]               pe_valid;
  logic [NUM_PE*DATA_BITWIDTH-1:0] pe_data;
  logic                            cfg_write;
  logic                            ready;
  logic                            accept;

  // Clear has priority over a same-cycle ID write.
  assign cfg_write = (state == CFG) & bus.i_id_cfg_valid & ~bus.i_cfg_clear;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= CFG;
      idx      <= '0;
      cfg_done <= 1'b0;
    end else if (bus.i_cfg_clear) begin
      state    <= CFG;
      idx      <= '0;
      cfg_done <= 1'b0;
    end else if (cfg_write) begin
      if (idx == LAST_IDX) begin
        state    <= RUN;
        cfg_done <= 1'b1;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // IDs survive a reconfiguration request until rewritten.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < int'(NUM_PE); k++) id_reg[k] <= '0;
    end else if (cfg_write) begin
      id_reg[idx] <= bus.i_id_cfg_data;
    end
  end

  always_comb begin
    match = '0;
    for (int k = 0; k < int'(NUM_PE); k++) begin
      match[k] = (bus.i_tag == id_reg[k]) | (bus.i_tag == ALL_ONES);
    end
  end

  // A word is taken only if every matched PE can take it; no match is always taken.
  assign ready  = (state == RUN) & (&(~match | slot_free));
  assign accept = bus.i_valid & ready;
  assign load   = match & {NUM_PE{accept}};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      drop_cnt <= '0;
    end else if (accept && (match == '0) && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end

  for (genvar k = 0; k < NUM_PE; k++) begin : g_slot
    gin_mc_slot #(
      .DATA_BITWIDTH(DATA_BITWIDTH)
    ) u_slot (
      .clk   (i_clk),
      .rst_n (i_rst),
      .load  (load[k]),
      .wdata (bus.i_data),
      .ready (bus.i_pe_ready[k]),
      .valid (pe_valid[k]),
      .rdata (pe_data[k*DATA_BITWIDTH +: DATA_BITWIDTH]),
      .free  (slot_free[k])
    );
  end

  assign bus.o_ready    = ready;
  assign bus.o_cfg_done = cfg_done;
  assign bus.o_pe_valid = pe_valid;
  assign bus.o_pe_data  = pe_data;
  assign bus.o_drop_cnt = drop_cnt;
  assign bus.o_busy     = |pe_valid;

endmodule

// File: tb/tb_gin_mc_bus.sv
// Bench for gin_mc_bus: randomized traffic against a reference model, plus a
// narrow-counter twin instance for drop saturation.
module tb_gin_mc_bus;

  localparam int unsigned DW  = 8;
  localparam int unsigned IW  = 5;
  localparam int unsigned NP  = 12;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW2 = 2;

  logic i_clk;
  logic i_rst;

  gin_mc_bus_if #(.DATA_BITWIDTH(DW), .ID_WIDTH(IW), .NUM_PE(NP), .DROP_CNT_WIDTH(CW))  bus ();
  gin_mc_bus_if #(.DATA_BITWIDTH(DW), .ID_WIDTH(IW), .NUM_PE(NP), .DROP_CNT_WIDTH(CW2)) bus2 ();

  gin_mc_bus #(.DATA_BITWIDTH(DW), .ID_WIDTH(IW), .NUM_PE(NP), .DROP_CNT_WIDTH(CW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  gin_mc_bus #(.DATA_BITWIDTH(DW), .ID_WIDTH(IW), .NUM_PE(NP), .DROP_CNT_WIDTH(CW2)) dut_sat (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus2)
  );

  assign bus2.i_cfg_clear    = bus.i_cfg_clear;
  assign bus2.i_id_cfg_valid = bus.i_id_cfg_valid;
  assign bus2.i_id_cfg_data  = bus.i_id_cfg_data;
  assign bus2.i_tag          = bus.i_tag;
  assign bus2.i_data         = bus.i_data;
  assign bus2.i_valid        = bus.i_valid;
  assign bus2.i_pe_ready     = bus.i_pe_ready;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int  vectors = 0;
  int  miss    = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what each PE should hold, which IDs are loaded, words dropped.
  logic [IW-1:0] m_ids [NP];
  logic [DW-1:0] m_d   [NP];
  logic [NP-1:0] m_v;
  logic          m_run;
  logic          m_done;
  int            m_idx;
  int unsigned   m_drop;

  function automatic logic m_hit(input int k, input logic [IW-1:0] tag);
    return (tag == '1) || (tag == m_ids[k]);
  endfunction

  function automatic logic m_ready_now();
    if (!m_run) return 1'b0;
    for (int k = 0; k < int'(NP); k++)
      if (m_hit(k, bus.i_tag) && m_v[k] && !bus.i_pe_ready[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_run = 1'b0; m_done = 1'b0; m_idx = 0; m_drop = 0; m_v = '0;
    for (int k = 0; k < int'(NP); k++) begin
      m_ids[k] = '0;
      m_d[k]   = '0;
    end
  endtask

  task automatic m_step();
    logic acc;
    logic any;
    acc = bus.i_valid && m_ready_now();
    any = 1'b0;
    for (int k = 0; k < int'(NP); k++) begin
      if (m_hit(k, bus.i_tag)) any = 1'b1;
      if (acc && m_hit(k, bus.i_tag)) begin
        m_v[k] = 1'b1;
        m_d[k] = bus.i_data;
      end else if (bus.i_pe_ready[k]) begin
        m_v[k] = 1'b0;
      end
    end
    if (acc && !any) m_drop++;
    if (bus.i_cfg_clear) begin
      m_run = 1'b0; m_done = 1'b0; m_idx = 0;
    end else if (!m_run && bus.i_id_cfg_valid) begin
      m_ids[m_idx] = bus.i_id_cfg_data;
      if (m_idx == int'(NP) - 1) begin
        m_run = 1'b1; m_done = 1'b1;
      end else begin
        m_idx++;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge i_clk or negedge i_rst);
      if (!i_rst) m_reset();
      else m_step();
    end
  end

  // Compare both instances against the model mid-cycle.
  initial forever begin
    @(negedge i_clk);
    if (chk_en) begin
      chk("ready", 64'(bus.o_ready), 64'(m_ready_now()));
      chk("cfg_done", 64'(bus.o_cfg_done), 64'(m_done));
      chk("drop_cnt", 64'(bus.o_drop_cnt), 64'((m_drop > 65535) ? 65535 : m_drop));
      chk("busy", 64'(bus.o_busy), 64'(|m_v));
      chk("pe_valid", 64'(bus.o_pe_valid), 64'(m_v));
      chk("sat_ready", 64'(bus2.o_ready), 64'(m_ready_now()));
      chk("sat_pe_valid", 64'(bus2.o_pe_valid), 64'(m_v));
      chk("sat_drop_cnt", 64'(bus2.o_drop_cnt), 64'((m_drop > 3) ? 3 : m_drop));
      for (int k = 0; k < int'(NP); k++) begin
        chk($sformatf("pe_data[%0d]", k), 64'(bus.o_pe_data[k*DW +: DW]), 64'(m_d[k]));
        chk($sformatf("sat_pe_data[%0d]", k), 64'(bus2.o_pe_data[k*DW +: DW]), 64'(m_d[k]));
      end
    end
  end

  logic [IW-1:0] cfg_tab [NP];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid        = 1'b0;
    bus.i_id_cfg_valid = 1'b0;
    bus.i_cfg_clear    = 1'b0;
  endtask

  task automatic send(input logic [IW-1:0] tag, input logic [DW-1:0] d, input logic [NP-1:0] rdy);
    bus.i_valid    = 1'b1;
    bus.i_tag      = tag;
    bus.i_data     = d;
    bus.i_pe_ready = rdy;
  endtask

  task automatic load_ids(input int n);
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.i_id_cfg_valid = 1'b0;
        tick();
      end
      bus.i_id_cfg_valid = 1'b1;
      bus.i_id_cfg_data  = cfg_tab[k];
      tick();
    end
    bus.i_id_cfg_valid = 1'b0;
  endtask

  task automatic rnd_cycle(input bit with_cfg);
    int r;
    r = $urandom_range(0, 7);
    bus.i_valid = ($urandom_range(0, 3) != 0);
    case (r)
      0:       bus.i_tag = '1;
      1:       bus.i_tag = IW'(20);
      default: bus.i_tag = IW'($urandom_range(0, 13));
    endcase
    bus.i_data         = DW'($urandom);
    bus.i_pe_ready     = NP'($urandom | $urandom);
    bus.i_cfg_clear    = with_cfg && ($urandom_range(0, 39) == 0);
    bus.i_id_cfg_valid = with_cfg && ($urandom_range(0, 2) == 0);
    bus.i_id_cfg_data  = IW'($urandom_range(0, 12));
    tick();
  endtask

  initial begin
    i_rst          = 1'b0;
    bus.i_tag      = '0;
    bus.i_data     = '0;
    bus.i_pe_ready = '1;
    bus.i_id_cfg_data = '0;
    idle();
    repeat (2) tick();

    // Reset values
    chk("rst_pe_valid", 64'(bus.o_pe_valid), 64'h0);
    chk("rst_drop_cnt", 64'(bus.o_drop_cnt), 64'h0);
    chk("rst_cfg_done", 64'(bus.o_cfg_done), 64'h0);
    chk("rst_ready", 64'(bus.o_ready), 64'h0);
    chk("rst_busy", 64'(bus.o_busy), 64'h0);
    i_rst  = 1'b1;
    chk_en = 1'b1;
    tick();

    // ID load 0..11 and unicast
    for (int k = 0; k < int'(NP); k++) cfg_tab[k] = IW'(k);
    load_ids(NP);
    chk("cfg_done_after_load", 64'(bus.o_cfg_done), 64'h1);
    send(IW'(3), 8'hA5, '1);
    #1 chk("unicast_ready", 64'(bus.o_ready), 64'h1);
    tick();
    idle();
    chk("unicast_valid", 64'(bus.o_pe_valid), 64'h008);
    chk("unicast_data", 64'(bus.o_pe_data[3*DW +: DW]), 64'hA5);
    tick();

    // Broadcast blocked by full slot 7
    send(IW'(7), 8'h11, 12'hF7F);
    tick();
    send('1, 8'h5C, 12'hF7F);
    #1 chk("bcast_blocked_ready", 64'(bus.o_ready), 64'h0);
    tick();
    chk("bcast_blocked_valid", 64'(bus.o_pe_valid), 64'h080);
    send('1, 8'h5C, 12'hFFF);
    #1 chk("bcast_release_ready", 64'(bus.o_ready), 64'h1);
    tick();
    idle();
    chk("bcast_all_valid", 64'(bus.o_pe_valid), 64'hFFF);
    chk("bcast_slot7_data", 64'(bus.o_pe_data[7*DW +: DW]), 64'h5C);
    tick();

    repeat (300) rnd_cycle(1'b0);

    // Reconfiguration while slots 0 and 1 hold data
    idle();
    bus.i_pe_ready = '1;
    tick();
    send(IW'(0), 8'h21, 12'hFFC);
    tick();
    send(IW'(1), 8'h22, 12'hFFC);
    tick();
    idle();
    bus.i_cfg_clear = 1'b1;
    tick();
    bus.i_cfg_clear = 1'b0;
    chk("reconf_cfg_done", 64'(bus.o_cfg_done), 64'h0);
    chk("reconf_ready", 64'(bus.o_ready), 64'h0);
    chk("reconf_held", 64'(bus.o_pe_valid), 64'h003);
    bus.i_pe_ready = '1;
    tick();
    chk("reconf_drained", 64'(bus.o_pe_valid), 64'h000);
    cfg_tab = '{IW'(0), IW'(1), IW'(4), IW'(3), IW'(6), IW'(4),
                IW'(7), IW'(8), IW'(10), IW'(4), IW'(11), IW'(12)};
    load_ids(5);
    bus.i_cfg_clear    = 1'b1;
    bus.i_id_cfg_valid = 1'b1;
    bus.i_id_cfg_data  = '1;
    tick();
    idle();
    load_ids(NP);
    chk("reconf_done", 64'(bus.o_cfg_done), 64'h1);

    // Multicast to duplicate ID 4
    send(IW'(4), 8'h44, '1);
    tick();
    idle();
    chk("mcast_valid", 64'(bus.o_pe_valid), 64'h224);
    tick();

    // Asynchronous reset with four slots full
    send(IW'(4), 8'h55, 12'h000);
    tick();
    send(IW'(0), 8'h66, 12'h000);
    tick();
    idle();
    chk("pre_rst_valid", 64'(bus.o_pe_valid), 64'h225);
    i_rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.o_pe_valid), 64'h0);
    chk("async_rst_drop", 64'(bus.o_drop_cnt), 64'h0);
    chk("async_rst_sat_drop", 64'(bus2.o_drop_cnt), 64'h0);
    chk("async_rst_cfg_done", 64'(bus.o_cfg_done), 64'h0);
    chk("async_rst_busy", 64'(bus.o_busy), 64'h0);
    repeat (2) tick();
    i_rst = 1'b1;
    bus.i_pe_ready = '1;
    tick();

    // Drops and saturation of the narrow counter
    load_ids(NP);
    send(IW'(20), 8'h01, '1);
    tick();
    idle();
    chk("drop_one", 64'(bus.o_drop_cnt), 64'h1);
    chk("sat_drop_one", 64'(bus2.o_drop_cnt), 64'h1);
    repeat (4) begin
      send(IW'(20), 8'h02, '1);
      tick();
    end
    idle();
    chk("drop_five", 64'(bus.o_drop_cnt), 64'h5);
    chk("sat_drop_five", 64'(bus2.o_drop_cnt), 64'h3);

    repeat (400) rnd_cycle(1'b1);
    idle();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
